gray_rx_checker: RTL and testbench

Receive end of the gray-coded counter stream.
- Captures a gray-coded count word, decodes it to binary, and checks that successive valid samples advance by exactly +1 modulo 2^CBITS.
- Emits a pulse on each wrap to zero, and flags or counts sequence errors.
- Sits after the synchroniser on the consumer side of the gray counter interface.

---
 rtl/gray_pkg.sv | 31 +++
 rtl/gray2bin_dec.sv | 15 +
 rtl/gray_rx_checker.sv | 202 ++++++++++++++++++++
 tb/tb_gray_rx_checker.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// gray_pkg: shared types and helpers for the gray-coded counter interface.
//   GRAY_CBITS   default count-word width
//   gray_rx_st_e receive-checker lock state
//   gray2bin()   gray -> binary decode (up to 32 bits, zero-extend narrower words)
//   bin2gray()   binary -> gray encode, used by the transmit side
package gray_pkg;

    localparam int unsigned GRAY_CBITS = 12;
    localparam int unsigned GRAY_FN_W  = 32;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        TRACK    = 2'd1,
        ERROR    = 2'd2
    } gray_rx_st_e;

    // Zero upper bits contribute nothing to the prefix XOR, so narrower words decode correctly.
    function automatic logic [GRAY_FN_W-1:0] gray2bin(input logic [GRAY_FN_W-1:0] g);
        logic [GRAY_FN_W-1:0] b;
        b[GRAY_FN_W-1] = g[GRAY_FN_W-1];
        for (int i = GRAY_FN_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [GRAY_FN_W-1:0] bin2gray(input logic [GRAY_FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray2bin_dec.sv
// gray2bin_dec: purely combinational gray -> binary decoder (W <= 32).
//   gray  input  [W-1:0]  gray-coded word
//   bin   output [W-1:0]  decoded binary word
module gray2bin_dec
    import gray_pkg::*;
#(
    parameter int unsigned W = GRAY_CBITS
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    assign bin = W'(gray2bin(GRAY_FN_W'(gray)));

endmodule

// File: rtl/gray_rx_checker.sv
// gray_rx_checker: receive end of a gray-coded counter stream. Registers the
// sample, decodes it, checks for +1 mod 2^CBITS steps and tracks lock state.
//   clk, rst_n  clock (rising edge), async active-low reset
//   gray_in     gray-coded count sample, gray_vld qualifies it
//   bin_out     decoded binary value (holds when bin_vld=0), bin_vld qualifier
//   locked      high while in TRACK
//   zero_pls    in-sequence sample decoded to 0 (TRACK only)
//   err_pls     sequence error pulse; err_cnt saturating error count
//   ham_err     (only with GRAY_HAM_CHK_EN) gray step not a single-bit change
// Optional macro GRAY_HAM_CHK_EN adds the single-bit-transition check and ham_err.
module gray_rx_checker
    import gray_pkg::*;
#(
    parameter int unsigned CBITS  = GRAY_CBITS,
    parameter int unsigned RELOCK = 2,
    parameter int unsigned ECW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CBITS-1:0] gray_in,
    input  logic             gray_vld,
    output logic [CBITS-1:0] bin_out,
    output logic             bin_vld,
    output logic             locked,
    output logic             zero_pls,
    output logic             err_pls,
`ifdef GRAY_HAM_CHK_EN
    output logic             ham_err,
`endif
    output logic [ECW-1:0]   err_cnt
);

    localparam int unsigned RCW = 4;

    // Stage 1: input capture
    logic [CBITS-1:0] r_s1_gray;
    logic             r_s1_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_gray <= '0;
            r_s1_vld  <= 1'b0;
        end else begin
            r_s1_gray <= gray_in;
            r_s1_vld  <= gray_vld;
        end
    end

`ifdef GRAY_HAM_CHK_EN
    // Single-bit transition check against the previous valid gray word
    logic [CBITS-1:0] r_prev_gray;
    logic             r_prev_gray_ok;
    logic             r_s1_ham_bad;
    logic             w_ham_bad;

    assign w_ham_bad = gray_vld && r_prev_gray_ok &&
                       ($countones(gray_in ^ r_prev_gray) != 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_gray    <= '0;
            r_prev_gray_ok <= 1'b0;
            r_s1_ham_bad   <= 1'b0;
        end else begin
            r_s1_ham_bad <= w_ham_bad;
            if (gray_vld) begin
                r_prev_gray    <= gray_in;
                r_prev_gray_ok <= 1'b1;
            end
        end
    end
`endif

    // Stage 2: decode and sequence check
    logic [CBITS-1:0] w_bin;
    logic             w_good;

    gray2bin_dec #(.W(CBITS)) u_dec (
        .gray (r_s1_gray),
        .bin  (w_bin)
    );

    gray_rx_st_e      r_state, w_state_nxt;
    logic [CBITS-1:0] r_prev, w_prev_nxt;
    logic [RCW-1:0]   r_rcnt, w_rcnt_nxt, w_rcnt_inc;
    logic [CBITS-1:0] r_bin_out, w_bin_out_nxt;
    logic             r_bin_vld, w_bin_vld_nxt;
    logic             r_locked;
    logic             r_zero, w_zero_nxt;
    logic             r_err, w_err_nxt;
    logic [ECW-1:0]   r_err_cnt, w_err_cnt_nxt, w_err_cnt_inc;
    logic             w_ham_nxt;

`ifdef GRAY_HAM_CHK_EN
    assign w_good = (w_bin == r_prev + CBITS'(1)) && !r_s1_ham_bad;
`else
    assign w_good = (w_bin == r_prev + CBITS'(1));
`endif

    assign w_rcnt_inc    = r_rcnt + RCW'(1);
    assign w_err_cnt_inc = (&r_err_cnt) ? r_err_cnt : r_err_cnt + ECW'(1);

    // Next-state and output decode; advances only on valid stage-2 samples
    always_comb begin
        w_state_nxt   = r_state;
        w_prev_nxt    = r_prev;
        w_rcnt_nxt    = r_rcnt;
        w_bin_out_nxt = r_bin_out;
        w_bin_vld_nxt = 1'b0;
        w_zero_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_err_cnt_nxt = r_err_cnt;
        w_ham_nxt     = 1'b0;
        if (r_s1_vld) begin
            w_bin_out_nxt = w_bin;
            w_bin_vld_nxt = 1'b1;
            w_prev_nxt    = w_bin;
            case (r_state)
                UNLOCKED: begin
                    w_state_nxt = TRACK;
                    w_rcnt_nxt  = '0;
                end
                TRACK: begin
                    if (w_good) begin
                        w_zero_nxt = (w_bin == '0);
                    end else begin
                        w_err_nxt     = 1'b1;
                        w_err_cnt_nxt = w_err_cnt_inc;
                        w_state_nxt   = ERROR;
                        w_rcnt_nxt    = '0;
                    end
                end
                ERROR: begin
                    if (w_good) begin
                        if (w_rcnt_inc >= RCW'(RELOCK)) begin
                            w_state_nxt = TRACK;
                            w_rcnt_nxt  = '0;
                        end else begin
                            w_rcnt_nxt = w_rcnt_inc;
                        end
                    end else begin
                        w_err_nxt     = 1'b1;
                        w_err_cnt_nxt = w_err_cnt_inc;
                        w_rcnt_nxt    = '0;
                    end
                end
                default: begin
                    w_state_nxt = UNLOCKED;
                    w_rcnt_nxt  = '0;
                end
            endcase
`ifdef GRAY_HAM_CHK_EN
            w_ham_nxt = r_s1_ham_bad && (r_state != UNLOCKED);
`endif
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= UNLOCKED;
            r_prev    <= '0;
            r_rcnt    <= '0;
            r_bin_out <= '0;
            r_bin_vld <= 1'b0;
            r_locked  <= 1'b0;
            r_zero    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_prev    <= w_prev_nxt;
            r_rcnt    <= w_rcnt_nxt;
            r_bin_out <= w_bin_out_nxt;
            r_bin_vld <= w_bin_vld_nxt;
            r_locked  <= (w_state_nxt == TRACK);
            r_zero    <= w_zero_nxt;
            r_err     <= w_err_nxt;
            r_err_cnt <= w_err_cnt_nxt;
        end
    end

`ifdef GRAY_HAM_CHK_EN
    logic r_ham;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ham <= 1'b0;
        else        r_ham <= w_ham_nxt;
    end
    assign ham_err = r_ham;
`else
    logic w_ham_unused;
    assign w_ham_unused = w_ham_nxt;
`endif

    assign bin_out  = r_bin_out;
    assign bin_vld  = r_bin_vld;
    assign locked   = r_locked;
    assign zero_pls = r_zero;
    assign err_pls  = r_err;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_gray_rx_checker.sv
// tb_gray_rx_checker: directed bench for gray_rx_checker (CBITS=4, RELOCK=2, ECW=8).
// Inputs are driven and outputs sampled on the falling edge; outputs seen at
// a step reflect the sample driven two steps earlier.
// Define GRAY_HAM_CHK_EN to also exercise ham_err.
module tb_gray_rx_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] gray_in = '0;
    logic       gray_vld = 1'b0;
    logic [3:0] bin_out;
    logic       bin_vld;
    logic       locked;
    logic       zero_pls;
    logic       err_pls;
    logic [7:0] err_cnt;
`ifdef GRAY_HAM_CHK_EN
    logic       ham_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gray_rx_checker #(.CBITS(4), .RELOCK(2), .ECW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .gray_in  (gray_in),
        .gray_vld (gray_vld),
        .bin_out  (bin_out),
        .bin_vld  (bin_vld),
        .locked   (locked),
        .zero_pls (zero_pls),
        .err_pls  (err_pls),
`ifdef GRAY_HAM_CHK_EN
        .ham_err  (ham_err),
`endif
        .err_cnt  (err_cnt)
    );

    function automatic logic [3:0] g(input int b);
        logic [3:0] x;
        x = 4'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check outputs at this falling edge, then drive the next sample.
    task automatic step(input logic [3:0] gi, input logic v,
                        input logic e_vld, input int e_bin, input logic e_lk,
                        input logic e_z, input logic e_e, input int e_cnt,
                        input string tag);
        @(negedge clk);
        chk({tag, "/bin_vld"},  32'(bin_vld),  32'(e_vld));
        chk({tag, "/bin_out"},  32'(bin_out),  32'(e_bin));
        chk({tag, "/locked"},   32'(locked),   32'(e_lk));
        chk({tag, "/zero_pls"}, 32'(zero_pls), 32'(e_z));
        chk({tag, "/err_pls"},  32'(err_pls),  32'(e_e));
        chk({tag, "/err_cnt"},  32'(err_cnt),  32'(e_cnt));
        gray_in  = gi;
        gray_vld = v;
    endtask

    task automatic drive(input logic [3:0] gi, input logic v);
        @(negedge clk);
        gray_in  = gi;
        gray_vld = v;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n    = 1'b0;
        gray_in  = '0;
        gray_vld = 1'b0;
        #1;
        chk({tag, "/rst_bin_out"},  32'(bin_out),  32'd0);
        chk({tag, "/rst_bin_vld"},  32'(bin_vld),  32'd0);
        chk({tag, "/rst_locked"},   32'(locked),   32'd0);
        chk({tag, "/rst_zero_pls"}, 32'(zero_pls), 32'd0);
        chk({tag, "/rst_err_pls"},  32'(err_pls),  32'd0);
        chk({tag, "/rst_err_cnt"},  32'(err_cnt),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Count 0..15,0,1 back to back
        do_reset("s1");
        for (int i = 0; i <= 20; i++) begin
            step((i < 18) ? g(i % 16) : 4'h0, (i < 18),
                 (i >= 2 && i <= 19),
                 (i < 2) ? 0 : ((i <= 19) ? (i - 2) % 16 : 1),
                 (i >= 2), (i == 18), 1'b0, 0, $sformatf("s1_%0d", i));
        end

        // 3,4,6,7,8: error at 6, relock at 8
        do_reset("s2");
        step(g(3), 1, 0, 0, 0, 0, 0, 0, "s2_0");
        step(g(4), 1, 0, 0, 0, 0, 0, 0, "s2_1");
        step(g(6), 1, 1, 3, 1, 0, 0, 0, "s2_2");
        step(g(7), 1, 1, 4, 1, 0, 0, 0, "s2_3");
        step(g(8), 1, 1, 6, 0, 0, 1, 1, "s2_4");
        step(4'h0, 0, 1, 7, 0, 0, 0, 1, "s2_5");
        step(4'h0, 0, 1, 8, 1, 0, 0, 1, "s2_6");
        step(4'h0, 0, 0, 8, 1, 0, 0, 1, "s2_7");

        // 4,5,5,6,7: stall is an error, relock at 7
        do_reset("s3");
        step(g(4), 1, 0, 0, 0, 0, 0, 0, "s3_0");
        step(g(5), 1, 0, 0, 0, 0, 0, 0, "s3_1");
        step(g(5), 1, 1, 4, 1, 0, 0, 0, "s3_2");
        step(g(6), 1, 1, 5, 1, 0, 0, 0, "s3_3");
        step(g(7), 1, 1, 5, 0, 0, 1, 1, "s3_4");
        step(4'h0, 0, 1, 6, 0, 0, 0, 1, "s3_5");
        step(4'h0, 0, 1, 7, 1, 0, 0, 1, "s3_6");
        step(4'h0, 0, 0, 7, 1, 0, 0, 1, "s3_7");

        // Valid toggling across 9,10,11: invalid cycles ignored
        do_reset("s4");
        step(g(8),  1, 0, 0,  0, 0, 0, 0, "s4_0");
        step(g(9),  1, 0, 0,  0, 0, 0, 0, "s4_1");
        step(g(9),  0, 1, 8,  1, 0, 0, 0, "s4_2");
        step(g(10), 1, 1, 9,  1, 0, 0, 0, "s4_3");
        step(g(3),  0, 0, 9,  1, 0, 0, 0, "s4_4");
        step(g(11), 1, 1, 10, 1, 0, 0, 0, "s4_5");
        step(4'h0,  0, 0, 10, 1, 0, 0, 0, "s4_6");
        step(4'h0,  0, 1, 11, 1, 0, 0, 0, "s4_7");
        step(4'h0,  0, 0, 11, 1, 0, 0, 0, "s4_8");

        // Reset mid-stream at 9, resume at 2
        do_reset("s5");
        step(g(7), 1, 0, 0, 0, 0, 0, 0, "s5_0");
        step(g(8), 1, 0, 0, 0, 0, 0, 0, "s5_1");
        step(g(9), 1, 1, 7, 1, 0, 0, 0, "s5_2");
        do_reset("s5_mid");
        step(g(2), 1, 0, 0, 0, 0, 0, 0, "s5_3");
        step(g(3), 1, 0, 0, 0, 0, 0, 0, "s5_4");
        step(4'h0, 0, 1, 2, 1, 0, 0, 0, "s5_5");
        step(4'h0, 0, 1, 3, 1, 0, 0, 0, "s5_6");

        // Error counter saturation: baseline 0 then repeated stalls
        do_reset("s6");
        for (int i = 0; i < 256; i++) drive(g(0), 1);
        drive(4'h0, 0);
        drive(4'h0, 0);
        @(negedge clk);
        chk("s6/cnt_255", 32'(err_cnt), 32'd255);
        for (int i = 0; i < 45; i++) drive(g(0), 1);
        drive(4'h0, 0);
        drive(4'h0, 0);
        @(negedge clk);
        chk("s6/cnt_sat", 32'(err_cnt), 32'd255);
        chk("s6/locked",  32'(locked),  32'd0);

`ifdef GRAY_HAM_CHK_EN
        // Gray 0000 -> 0011 is a two-bit jump
        do_reset("s7");
        step(4'b0000, 1, 0, 0, 0, 0, 0, 0, "s7_0");
        step(4'b0011, 1, 0, 0, 0, 0, 0, 0, "s7_1");
        step(4'h0,    0, 1, 0, 1, 0, 0, 0, "s7_2");
        chk("s7/ham_idle", 32'(ham_err), 32'd0);
        step(4'h0,    0, 1, 2, 0, 0, 1, 1, "s7_3");
        chk("s7/ham_err", 32'(ham_err), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
